// File: rtl/mouse_pkg.sv
// mouse_pkg: shared definitions for the PS/2 mouse master sequencer.
//   - state_t : master FSM states with fixed 4-bit codes (shown on debug LEDs)
//   - command / response byte constants exchanged with the mouse
//   - receiver error-code constants and a byte acceptance helper
package mouse_pkg;

    typedef enum logic [3:0] {
        ST_INIT          = 4'd0,
        ST_SEND_RESET    = 4'd1,
        ST_WAIT_SENT_RST = 4'd2,
        ST_WAIT_ACK_RST  = 4'd3,
        ST_WAIT_SELFTEST = 4'd4,
        ST_WAIT_ID       = 4'd5,
        ST_SEND_ENABLE   = 4'd6,
        ST_WAIT_SENT_EN  = 4'd7,
        ST_WAIT_ACK_EN   = 4'd8,
        ST_READ_B1       = 4'd9,
        ST_READ_B2       = 4'd10,
        ST_READ_B3       = 4'd11,
        ST_PUBLISH       = 4'd12
    } state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    // A received byte is usable only when the receiver flagged no framing/parity error.
    function automatic logic byte_clean(input logic [1:0] err);
        return (err == ERR_NONE);
    endfunction

    // Clean byte that also equals the response the sequencer is waiting for.
    function automatic logic rsp_match(input logic [1:0] err,
                                       input logic [7:0] data,
                                       input logic [7:0] expected);
        return byte_clean(err) && (data == expected);
    endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// mouse_timeout_counter: shared delay / timeout counter.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : synchronous clear to zero (has priority over enable)
//   enable   : count up by one per cycle
//   limit    : number of cycles the window lasts
//   expired  : high while the count sits at limit-1 (last cycle of the window)
module mouse_timeout_counter #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Counter register: clear wins, otherwise count while enabled, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clear) begin
            count_r <= {W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == (limit - ONE));

endmodule

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse initialisation and stream-mode packet sequencer.
//   CLK, RESET              : clock, asynchronous active-high reset
//   SEND_BYTE, BYTE_TO_SEND : one-cycle command request and its byte (to transmitter)
//   BYTE_SENT               : transmitter completion pulse
//   READ_ENABLE             : receiver enable
//   BYTE_READ, BYTE_ERROR_CODE, BYTE_READY : received byte, error flags, valid pulse
//   MOUSE_STATUS/DX/DY      : last complete 3-byte packet
//   SEND_INTERRUPT          : one-cycle pulse when a new packet is published
//   MASTER_STATE_CODE       : current FSM state for debug LEDs
module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int INIT_DELAY       = 5_000_000,
    parameter int TIMEOUT_CYCLES   = 100_000,
    parameter int SELFTEST_TIMEOUT = 50_000_000,
    parameter int CNT_W            = 26
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic [3:0] MASTER_STATE_CODE
);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] limit_s;
    logic             expired_s;
    logic             rx_en_s;
    logic [7:0]       status_sh_r;
    logic [7:0]       dx_sh_r;

    // READ_B1 has no timeout (the mouse may idle), so the counter is frozen there.
    mouse_timeout_counter #(.W(CNT_W)) u_timer (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (next_state_s != state_r),
        .enable  (state_r != ST_READ_B1),
        .limit   (limit_s),
        .expired (expired_s)
    );

    // Window length for the state currently being timed.
    always_comb begin
        limit_s = CNT_W'(TIMEOUT_CYCLES);
        case (state_r)
            ST_INIT:          limit_s = CNT_W'(INIT_DELAY);
            ST_WAIT_SELFTEST: limit_s = CNT_W'(SELFTEST_TIMEOUT);
            ST_WAIT_ID:       limit_s = CNT_W'(SELFTEST_TIMEOUT);
            default:          limit_s = CNT_W'(TIMEOUT_CYCLES);
        endcase
    end

    // Next-state logic; a byte arriving in the same cycle as a timeout takes precedence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (expired_s) next_state_s = ST_SEND_RESET;
                else           next_state_s = state_r;
            end
            ST_SEND_RESET: next_state_s = ST_WAIT_SENT_RST;
            ST_WAIT_SENT_RST: begin
                if (BYTE_SENT)      next_state_s = ST_WAIT_ACK_RST;
                else if (expired_s) next_state_s = ST_SEND_RESET;
                else                next_state_s = state_r;
            end
            ST_WAIT_ACK_RST: begin
                if (BYTE_READY)     next_state_s = rsp_match(BYTE_ERROR_CODE, BYTE_READ, RSP_ACK)
                                                 ? ST_WAIT_SELFTEST : ST_SEND_RESET;
                else if (expired_s) next_state_s = ST_SEND_RESET;
                else                next_state_s = state_r;
            end
            ST_WAIT_SELFTEST: begin
                if (BYTE_READY)     next_state_s = rsp_match(BYTE_ERROR_CODE, BYTE_READ, RSP_SELFTEST)
                                                 ? ST_WAIT_ID : ST_SEND_RESET;
                else if (expired_s) next_state_s = ST_SEND_RESET;
                else                next_state_s = state_r;
            end
            ST_WAIT_ID: begin
                if (BYTE_READY)     next_state_s = rsp_match(BYTE_ERROR_CODE, BYTE_READ, RSP_ID)
                                                 ? ST_SEND_ENABLE : ST_SEND_RESET;
                else if (expired_s) next_state_s = ST_SEND_RESET;
                else                next_state_s = state_r;
            end
            ST_SEND_ENABLE: next_state_s = ST_WAIT_SENT_EN;
            ST_WAIT_SENT_EN: begin
                if (BYTE_SENT)      next_state_s = ST_WAIT_ACK_EN;
                else if (expired_s) next_state_s = ST_SEND_RESET;
                else                next_state_s = state_r;
            end
            ST_WAIT_ACK_EN: begin
                if (BYTE_READY)     next_state_s = rsp_match(BYTE_ERROR_CODE, BYTE_READ, RSP_ACK)
                                                 ? ST_READ_B1 : ST_SEND_RESET;
                else if (expired_s) next_state_s = ST_SEND_RESET;
                else                next_state_s = state_r;
            end
            ST_READ_B1: begin
                // Bit 3 is always set in a status byte; without it we are mid-packet, so resync.
                if (BYTE_READY && byte_clean(BYTE_ERROR_CODE) && BYTE_READ[3]) next_state_s = ST_READ_B2;
                else                                                           next_state_s = state_r;
            end
            ST_READ_B2: begin
                if (BYTE_READY)     next_state_s = byte_clean(BYTE_ERROR_CODE) ? ST_READ_B3 : ST_READ_B1;
                else if (expired_s) next_state_s = ST_READ_B1;
                else                next_state_s = state_r;
            end
            ST_READ_B3: begin
                if (BYTE_READY)     next_state_s = byte_clean(BYTE_ERROR_CODE) ? ST_PUBLISH : ST_READ_B1;
                else if (expired_s) next_state_s = ST_READ_B1;
                else                next_state_s = state_r;
            end
            ST_PUBLISH: next_state_s = ST_READ_B1;
            default:    next_state_s = ST_INIT;
        endcase
    end

    // Receiver is enabled in every state that can consume a byte.
    always_comb begin
        rx_en_s = 1'b0;
        case (next_state_s)
            ST_INIT, ST_SEND_RESET, ST_WAIT_SENT_RST,
            ST_SEND_ENABLE, ST_WAIT_SENT_EN: rx_en_s = 1'b0;
            default:                         rx_en_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_r <= ST_INIT;
        else       state_r <= next_state_s;
    end

    // Shadow registers for packet bytes 1 and 2; byte 3 goes straight to MOUSE_DY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            status_sh_r <= 8'h00;
            dx_sh_r     <= 8'h00;
        end else begin
            if (state_r == ST_READ_B1 && next_state_s == ST_READ_B2) status_sh_r <= BYTE_READ;
            else                                                     status_sh_r <= status_sh_r;
            if (state_r == ST_READ_B2 && next_state_s == ST_READ_B3) dx_sh_r <= BYTE_READ;
            else                                                     dx_sh_r <= dx_sh_r;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state they belong to;
    // the packet is published on the edge that enters PUBLISH, so data and interrupt appear together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'h00;
            READ_ENABLE    <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            MOUSE_STATUS   <= 8'h00;
            MOUSE_DX       <= 8'h00;
            MOUSE_DY       <= 8'h00;
        end else begin
            SEND_BYTE      <= (next_state_s == ST_SEND_RESET) || (next_state_s == ST_SEND_ENABLE);
            READ_ENABLE    <= rx_en_s;
            SEND_INTERRUPT <= (next_state_s == ST_PUBLISH);
            if (next_state_s == ST_SEND_RESET)       BYTE_TO_SEND <= CMD_RESET;
            else if (next_state_s == ST_SEND_ENABLE) BYTE_TO_SEND <= CMD_ENABLE;
            else                                     BYTE_TO_SEND <= BYTE_TO_SEND;
            if (next_state_s == ST_PUBLISH) begin
                MOUSE_STATUS <= status_sh_r;
                MOUSE_DX     <= dx_sh_r;
                MOUSE_DY     <= BYTE_READ;
            end else begin
                MOUSE_STATUS <= MOUSE_STATUS;
                MOUSE_DX     <= MOUSE_DX;
                MOUSE_DY     <= MOUSE_DY;
            end
        end
    end

    assign MASTER_STATE_CODE = state_r;

endmodule

// File: tb/tb_mouse_master_sm.sv
// tb_mouse_master_sm: directed self-checking bench for mouse_master_sm with short delays.
module tb_mouse_master_sm;
    import mouse_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic [3:0] MASTER_STATE_CODE;

    int total = 0;
    int bad = 0;

    mouse_master_sm #(
        .INIT_DELAY       (10),
        .TIMEOUT_CYCLES   (200),
        .SELFTEST_TIMEOUT (400),
        .CNT_W            (26)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .SEND_BYTE         (SEND_BYTE),
        .BYTE_TO_SEND      (BYTE_TO_SEND),
        .BYTE_SENT         (BYTE_SENT),
        .READ_ENABLE       (READ_ENABLE),
        .BYTE_READ         (BYTE_READ),
        .BYTE_ERROR_CODE   (BYTE_ERROR_CODE),
        .BYTE_READY        (BYTE_READY),
        .MOUSE_STATUS      (MOUSE_STATUS),
        .MOUSE_DX          (MOUSE_DX),
        .MOUSE_DY          (MOUSE_DY),
        .SEND_INTERRUPT    (SEND_INTERRUPT),
        .MASTER_STATE_CODE (MASTER_STATE_CODE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rx(input logic [7:0] d, input logic [1:0] e);
        BYTE_READ = d;
        BYTE_ERROR_CODE = e;
        BYTE_READY = 1'b1;
        tick();
        BYTE_READY = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic sent();
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        total++;
        if ({SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, SEND_INTERRUPT} !== 11'h000) begin
            bad++;
            $display("FAIL reset_ctrl: got %h want 000", {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, SEND_INTERRUPT});
        end
        total++;
        if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MASTER_STATE_CODE} !== 28'h0000000) begin
            bad++;
            $display("FAIL reset_data: got %h want 0000000", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MASTER_STATE_CODE});
        end
    endtask

    // Release reset and expect the 0xFF command exactly 10 clocks later.
    task automatic test_init_delay(input string tag);
        int first;
        first = -1;
        RESET = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (first < 0 && SEND_BYTE === 1'b1) first = i;
            if (first >= 0) break;
        end
        total++;
        if (first != 10) begin
            bad++;
            $display("FAIL %s_delay: first SEND_BYTE at cycle %0d want 10", tag, first);
        end
        total++;
        if ({BYTE_TO_SEND, READ_ENABLE, MASTER_STATE_CODE} !== 13'h1FE1) begin
            bad++;
            $display("FAIL %s_cmd_ff: got %h want 1fe1", tag, {BYTE_TO_SEND, READ_ENABLE, MASTER_STATE_CODE});
        end
    endtask

    task automatic test_happy_init();
        test_init_delay("init");
        tick();
        total++;
        if ({SEND_BYTE, BYTE_TO_SEND, MASTER_STATE_CODE} !== 13'h0FF2) begin
            bad++;
            $display("FAIL wait_sent_rst: got %h want 0ff2", {SEND_BYTE, BYTE_TO_SEND, MASTER_STATE_CODE});
        end
        sent();
        total++;
        if ({READ_ENABLE, MASTER_STATE_CODE} !== 5'h13) begin
            bad++;
            $display("FAIL wait_ack_rst: got %h want 13", {READ_ENABLE, MASTER_STATE_CODE});
        end
        rx(8'hFA, ERR_NONE);
        rx(8'hAA, ERR_NONE);
        total++;
        if (MASTER_STATE_CODE !== 4'd5) begin
            bad++;
            $display("FAIL after_selftest: got %0d want 5", MASTER_STATE_CODE);
        end
        rx(8'h00, ERR_NONE);
        total++;
        if ({SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MASTER_STATE_CODE} !== 14'h3E86) begin
            bad++;
            $display("FAIL cmd_f4: got %h want 3e86", {SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MASTER_STATE_CODE});
        end
        tick();
        sent();
        rx(8'hFA, ERR_NONE);
        total++;
        if ({SEND_BYTE, READ_ENABLE, MASTER_STATE_CODE} !== 6'h19) begin
            bad++;
            $display("FAIL stream_b1: got %h want 19", {SEND_BYTE, READ_ENABLE, MASTER_STATE_CODE});
        end
    endtask

    task automatic test_packet();
        rx(8'h08, ERR_NONE);
        rx(8'h05, ERR_NONE);
        total++;
        if ({SEND_INTERRUPT, MASTER_STATE_CODE} !== 5'h0B) begin
            bad++;
            $display("FAIL pkt_b3_wait: got %h want 0b", {SEND_INTERRUPT, MASTER_STATE_CODE});
        end
        rx(8'hFB, ERR_NONE);
        total++;
        if ({SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 25'h10805FB) begin
            bad++;
            $display("FAIL pkt_publish: got %h want 10805fb", {SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
        tick();
        total++;
        if ({SEND_INTERRUPT, MASTER_STATE_CODE, MOUSE_DY} !== 13'h09FB) begin
            bad++;
            $display("FAIL pkt_irq_one_cycle: got %h want 09fb", {SEND_INTERRUPT, MASTER_STATE_CODE, MOUSE_DY});
        end
    endtask

    task automatic test_parity_error();
        rx(8'h09, ERR_NONE);
        rx(8'h01, ERR_PARITY);
        total++;
        if ({SEND_INTERRUPT, MASTER_STATE_CODE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 29'h090805FB) begin
            bad++;
            $display("FAIL parity_drop: got %h want 090805fb",
                     {SEND_INTERRUPT, MASTER_STATE_CODE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
        rx(8'h08, ERR_STOP);
        total++;
        if (MASTER_STATE_CODE !== 4'd9) begin
            bad++;
            $display("FAIL stop_err_b1: got %0d want 9", MASTER_STATE_CODE);
        end
        rx(8'h09, ERR_NONE);
        rx(8'h01, ERR_NONE);
        rx(8'h02, ERR_NONE);
        total++;
        if ({SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 25'h1090102) begin
            bad++;
            $display("FAIL parity_recover: got %h want 1090102", {SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
        tick();
    endtask

    task automatic test_sync_loss();
        rx(8'h00, ERR_NONE);
        total++;
        if ({SEND_INTERRUPT, MASTER_STATE_CODE} !== 5'h09) begin
            bad++;
            $display("FAIL sync_discard: got %h want 09", {SEND_INTERRUPT, MASTER_STATE_CODE});
        end
        rx(8'h18, ERR_NONE);
        rx(8'hFF, ERR_NONE);
        rx(8'h01, ERR_NONE);
        total++;
        if ({SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 25'h118FF01) begin
            bad++;
            $display("FAIL sync_packet: got %h want 118ff01", {SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
        tick();
    endtask

    // Partial packet times out after exactly 200 cycles in READ_B2.
    task automatic test_b2_timeout();
        rx(8'h08, ERR_NONE);
        for (int i = 0; i < 199; i++) tick();
        total++;
        if (MASTER_STATE_CODE !== 4'd10) begin
            bad++;
            $display("FAIL b2_before_timeout: got %0d want 10", MASTER_STATE_CODE);
        end
        tick();
        total++;
        if ({SEND_INTERRUPT, MASTER_STATE_CODE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 29'h0918FF01) begin
            bad++;
            $display("FAIL b2_timeout: got %h want 0918ff01",
                     {SEND_INTERRUPT, MASTER_STATE_CODE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY});
        end
    endtask

    task automatic test_reset_mid();
        rx(8'h08, ERR_NONE);
        #2;
        RESET = 1'b1;
        #1;
        total++;
        if ({SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MASTER_STATE_CODE} !== 31'h0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0",
                     {SEND_BYTE, READ_ENABLE, SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MASTER_STATE_CODE});
        end
        tick();
        test_init_delay("reinit");
    endtask

    task automatic test_bad_ack();
        tick();
        rx(8'hFA, ERR_NONE);
        total++;
        if ({READ_ENABLE, MASTER_STATE_CODE} !== 5'h02) begin
            bad++;
            $display("FAIL ignore_rx_wait_sent: got %h want 02", {READ_ENABLE, MASTER_STATE_CODE});
        end
        sent();
        rx(8'hFE, ERR_NONE);
        total++;
        if ({SEND_BYTE, BYTE_TO_SEND, MASTER_STATE_CODE} !== 13'h1FF1) begin
            bad++;
            $display("FAIL bad_ack_resend: got %h want 1ff1", {SEND_BYTE, BYTE_TO_SEND, MASTER_STATE_CODE});
        end
        tick();
        sent();
        for (int i = 0; i < 199; i++) tick();
        total++;
        if ({SEND_BYTE, MASTER_STATE_CODE} !== 5'h03) begin
            bad++;
            $display("FAIL ack_before_timeout: got %h want 03", {SEND_BYTE, MASTER_STATE_CODE});
        end
        tick();
        total++;
        if ({SEND_BYTE, BYTE_TO_SEND, MASTER_STATE_CODE} !== 13'h1FF1) begin
            bad++;
            $display("FAIL ack_timeout_resend: got %h want 1ff1", {SEND_BYTE, BYTE_TO_SEND, MASTER_STATE_CODE});
        end
        tick();
        sent();
        rx(8'hFA, ERR_STOP);
        total++;
        if (MASTER_STATE_CODE !== 4'd1) begin
            bad++;
            $display("FAIL ack_with_error: got %0d want 1", MASTER_STATE_CODE);
        end
    endtask

    initial begin
        test_reset();
        test_happy_init();
        test_packet();
        test_parity_error();
        test_sync_loss();
        test_b2_timeout();
        test_reset_mid();
        test_bad_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
